// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared types and constants for the RAM arbiter slice.
//   state_t : arbiter FSM state (IDLE = no read outstanding, BUSY = read in flight)
//   owner_t : requester that issued the outstanding read
//   WORD_SHIFT : byte-to-word address shift for 64-bit RAM words
package ram_arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        OWN_IF,
        OWN_MEM
    } owner_t;

    localparam int WORD_SHIFT = 3;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick
// Combinational grant picker for the RAM arbiter. MEM has fixed priority over
// IF, except that once MEM has won MAX_MEM_RUN times in a row while IF was
// waiting, IF is forced through.
// Ports:
//   if_req, mem_req : pending requests
//   run_cnt         : consecutive MEM grants taken while IF was waiting
//   allow           : RAM can accept a new command this cycle
//   if_gnt, mem_gnt : one-hot (or zero) grant
module ram_arb_pick #(
    parameter int MAX_MEM_RUN = 4,
    parameter int RUN_W       = 3
) (
    input  logic             if_req,
    input  logic             mem_req,
    input  logic [RUN_W-1:0] run_cnt,
    input  logic             allow,
    output logic             if_gnt,
    output logic             mem_gnt
);

    logic starved;

    // IF counts as starved once the MEM run counter has saturated.
    assign starved = (run_cnt == RUN_W'(MAX_MEM_RUN));

    // MEM wins unless IF is both waiting and starved; IF takes whatever is left.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (allow) begin
            if (mem_req && !(if_req && starved)) begin
                mem_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares a single-port synchronous RAM between the instruction-fetch port (IF,
// read-only) and the load/store port (MEM, read/write). Tracks the RAM read
// latency and routes each read response back to the port that issued it.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   if_req/if_addr                 : IF read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata      : IF accept strobe and read response
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wmask            : MEM request (held until mem_gnt)
//   mem_gnt/mem_rvalid/mem_rdata   : MEM accept strobe and read response
//   ram_en/ram_we/ram_addr/
//   ram_wdata/ram_wmask/ram_rdata  : RAM command and read data
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                ADDR_W      = 64,
    parameter int                DATA_W      = 64,
    parameter int                RAM_AW      = 16,
    parameter logic [ADDR_W-1:0] BASE        = 'h8000_0000,
    parameter int                RAM_LAT     = 1,
    parameter int                MAX_MEM_RUN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wmask,
    output logic                mem_gnt,
    output logic                mem_rvalid,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                ram_en,
    output logic                ram_we,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wmask,
    input  logic [DATA_W-1:0]   ram_rdata
);

    // One spare bit keeps "lat_cnt > 1" a real comparison even when RAM_LAT is 1.
    localparam int LAT_W = $clog2(RAM_LAT + 1) + 1;
    localparam int RUN_W = ($clog2(MAX_MEM_RUN + 1) > 0) ? $clog2(MAX_MEM_RUN + 1) : 1;

    state_t             state, state_nxt;
    owner_t             owner, owner_nxt;
    logic [LAT_W-1:0]   lat_cnt, lat_nxt;
    logic               oor, oor_nxt;
    logic [RUN_W-1:0]   run_cnt, run_nxt;

    logic               allow;
    logic               any_gnt;
    logic               is_write;
    logic               rd_gnt;
    logic               in_range;
    logic               resp_now;
    logic [ADDR_W-1:0]  sel_addr;
    logic [ADDR_W-1:0]  offset;
    logic [RAM_AW-1:0]  word_idx;

    // A new command may go to the RAM when idle or in the last cycle of a read,
    // never while reset is held.
    assign allow = !rst && ((state == IDLE) || (lat_cnt == LAT_W'(1)));

    ram_arb_pick #(
        .MAX_MEM_RUN (MAX_MEM_RUN),
        .RUN_W       (RUN_W)
    ) u_pick (
        .if_req  (if_req),
        .mem_req (mem_req),
        .run_cnt (run_cnt),
        .allow   (allow),
        .if_gnt  (if_gnt),
        .mem_gnt (mem_gnt)
    );

    // Winner address decode. Anything below BASE wraps to a huge offset, so a
    // single "offset fits in the RAM" test plus the BASE compare covers both ends.
    assign any_gnt  = if_gnt | mem_gnt;
    assign is_write = mem_gnt & mem_we;
    assign rd_gnt   = any_gnt & ~is_write;
    assign sel_addr = mem_gnt ? mem_addr : if_addr;
    assign offset   = sel_addr - BASE;
    assign in_range = (sel_addr >= BASE) && ((offset >> (RAM_AW + WORD_SHIFT)) == '0);
    assign word_idx = RAM_AW'(offset >> WORD_SHIFT);

    // RAM command mux. Out-of-range accesses are granted but never reach the RAM.
    assign ram_en    = any_gnt & in_range;
    assign ram_we    = ram_en & is_write;
    assign ram_addr  = any_gnt ? word_idx : '0;
    assign ram_wdata = is_write ? mem_wdata : '0;
    assign ram_wmask = is_write ? mem_wmask : '0;

    // Read response steering: only the owner sees rvalid and data; an
    // out-of-range read returns zeros at the normal time.
    assign resp_now   = (state == BUSY) && (lat_cnt == LAT_W'(1));
    assign if_rvalid  = resp_now && (owner == OWN_IF);
    assign mem_rvalid = resp_now && (owner == OWN_MEM);
    assign if_rdata   = (if_rvalid && !oor) ? ram_rdata : '0;
    assign mem_rdata  = (mem_rvalid && !oor) ? ram_rdata : '0;

    // Next-state logic. While a read is still counting down nothing can be
    // granted; otherwise a read grant (re)loads the tracker and anything else
    // returns the FSM to IDLE.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        owner_nxt = owner;
        oor_nxt   = oor;
        if (lat_cnt > LAT_W'(1)) begin
            lat_nxt = lat_cnt - LAT_W'(1);
        end else if (rd_gnt) begin
            state_nxt = BUSY;
            lat_nxt   = LAT_W'(RAM_LAT);
            owner_nxt = mem_gnt ? OWN_MEM : OWN_IF;
            oor_nxt   = !in_range;
        end else begin
            state_nxt = IDLE;
            lat_nxt   = '0;
            owner_nxt = NONE;
            oor_nxt   = 1'b0;
        end
    end

    // Starvation counter: counts MEM wins while IF waits, cleared whenever IF
    // is served or stops asking.
    always_comb begin
        run_nxt = run_cnt;
        if (!if_req || if_gnt) begin
            run_nxt = '0;
        end else if (mem_gnt && (run_cnt < RUN_W'(MAX_MEM_RUN))) begin
            run_nxt = run_cnt + RUN_W'(1);
        end
    end

    // State registers; reset drops any outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            owner   <= NONE;
            oor     <= 1'b0;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            owner   <= owner_nxt;
            oor     <= oor_nxt;
            run_cnt <= run_nxt;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Scoreboard bench for ram_arbiter: expected read responses are queued at grant
// time and compared when rvalid appears. A second instance checks a RAM_LAT=2
// build.
module tb_ram_arbiter;

    localparam logic [63:0] BASE = 64'h8000_0000;

    typedef struct {
        bit          isMem;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [63:0] if_rdata;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic [7:0]  mem_wmask = '0;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_wmask;
    logic [63:0] ram_rdata = '0;

    logic        l2_if_req = 1'b0;
    logic [63:0] l2_if_addr = '0;
    logic        l2_if_gnt, l2_if_rvalid;
    logic [63:0] l2_if_rdata;
    logic        l2_mem_gnt, l2_mem_rvalid;
    logic [63:0] l2_mem_rdata;
    logic        l2_ram_en, l2_ram_we;
    logic [15:0] l2_ram_addr;
    logic [63:0] l2_ram_wdata;
    logic [7:0]  l2_ram_wmask;
    logic [63:0] l2_p1 = '0;
    logic [63:0] l2_ram_rdata = '0;

    logic [63:0] ram   [0:65535];
    logic [63:0] model [0:65535];
    exp_t        expQ[$];

    int total = 0;
    int bad   = 0;

    ram_arbiter u_dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wmask  (ram_wmask),
        .ram_rdata  (ram_rdata)
    );

    ram_arbiter #(.RAM_LAT(2)) u_dut_lat2 (
        .clk        (clk),
        .rst        (rst),
        .if_req     (l2_if_req),
        .if_addr    (l2_if_addr),
        .if_gnt     (l2_if_gnt),
        .if_rvalid  (l2_if_rvalid),
        .if_rdata   (l2_if_rdata),
        .mem_req    (1'b0),
        .mem_we     (1'b0),
        .mem_addr   (64'h0),
        .mem_wdata  (64'h0),
        .mem_wmask  (8'h0),
        .mem_gnt    (l2_mem_gnt),
        .mem_rvalid (l2_mem_rvalid),
        .mem_rdata  (l2_mem_rdata),
        .ram_en     (l2_ram_en),
        .ram_we     (l2_ram_we),
        .ram_addr   (l2_ram_addr),
        .ram_wdata  (l2_ram_wdata),
        .ram_wmask  (l2_ram_wmask),
        .ram_rdata  (l2_ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency and byte-masked writes.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 8; b++) begin
                    if (ram_wmask[b]) ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end else begin
                ram_rdata <= ram[ram_addr];
            end
        end
    end

    // Two-cycle RAM for the latency-2 instance; contents are a fixed tag plus word address.
    always @(posedge clk) begin
        l2_p1        <= (l2_ram_en && !l2_ram_we) ? {48'hCAFE_0000_0000, l2_ram_addr} : 64'h0;
        l2_ram_rdata <= l2_p1;
    end

    function automatic bit inRange(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < 64'h8_0000);
    endfunction

    function automatic logic [15:0] wordOf(input logic [63:0] a);
        logic [63:0] o;
        o = a - BASE;
        return o[18:3];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one request (called just after a rising edge), waits for its grant,
    // checks the RAM command and records the expected response.
    task automatic applyStimulus(input bit useMem, input bit we, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [7:0] wmask,
                                 output int waited);
        logic [63:0] cur;
        if (useMem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_wmask = wmask;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        waited = 0;
        @(negedge clk);
        while (!(useMem ? mem_gnt : if_gnt) && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) begin
            checkOutput("gntTimeout", 64'(waited), 64'd0);
        end else begin
            checkOutput("ramEn", ram_en, inRange(addr));
            if (inRange(addr)) begin
                checkOutput("ramAddr", ram_addr, wordOf(addr));
                checkOutput("ramWe", ram_we, we);
            end
            if (!we) begin
                cur = inRange(addr) ? model[wordOf(addr)] : 64'h0;
                expQ.push_back('{useMem, cur});
            end else if (inRange(addr)) begin
                for (int b = 0; b < 8; b++) begin
                    if (wmask[b]) model[wordOf(addr)][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Response monitor: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (if_rvalid || mem_rvalid) begin
            checkOutput("rvalidExcl", 64'(if_rvalid & mem_rvalid), 64'd0);
            if (expQ.size() == 0) begin
                checkOutput("rvalidUnexpected", {62'd0, if_rvalid, mem_rvalid}, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rvalidPort", 64'(mem_rvalid), 64'(e.isMem));
                checkOutput("rdata", e.isMem ? mem_rdata : if_rdata, e.data);
                checkOutput("otherRdata", e.isMem ? if_rdata : mem_rdata, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        int run;
        int ifWord;
        int memWord;
        bit expMem;

        // Reset: outputs must be quiet even with both requests raised.
        if_req = 1'b1; mem_req = 1'b1; if_addr = BASE; mem_addr = BASE;
        #2;
        checkOutput("rstIfGnt", if_gnt, 0);
        checkOutput("rstMemGnt", mem_gnt, 0);
        checkOutput("rstRamEn", ram_en, 0);
        checkOutput("rstRamAddr", ram_addr, 0);
        checkOutput("rstIfRvalid", if_rvalid, 0);
        checkOutput("rstMemRvalid", mem_rvalid, 0);
        #5;
        if_req = 1'b0; mem_req = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] preload");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1, BASE + 64'(i) * 8, {32'hA5A5_0000 | 32'(i), 32'h5A5A_0000 | 32'(i)}, 8'hFF, w);
        end
        applyStimulus(1, 1, BASE + 64'h10, 64'hDEAD_BEEF_0000_0001, 8'hFF, w);
        applyStimulus(1, 1, 64'h8007_FFF8, 64'h0123_4567_89AB_CDEF, 8'hFF, w);

        $display("[TB] single IF reads");
        applyStimulus(0, 0, 64'h8000_0010, 64'h0, 8'h0, w);
        applyStimulus(0, 0, 64'h8000_0013, 64'h0, 8'h0, w);
        idleCycles(2);

        $display("[TB] MEM write then read");
        applyStimulus(1, 1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, w);
        applyStimulus(1, 0, 64'h8000_0008, 64'h0, 8'h0, w);
        checkOutput("wrRdBackToBack", 64'(w), 64'd0);
        applyStimulus(1, 1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, w);
        applyStimulus(1, 0, 64'h8000_0008, 64'h0, 8'h0, w);
        idleCycles(2);

        $display("[TB] both ports streaming");
        run = 0; ifWord = 0; memWord = 4;
        if_addr = BASE; mem_addr = BASE + 64'(memWord) * 8; mem_we = 1'b0;
        if_req = 1'b1; mem_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            expMem = (run != 4);
            checkOutput("pattern", {62'd0, if_gnt, mem_gnt}, expMem ? 64'd1 : 64'd2);
            if (mem_gnt) expQ.push_back('{1'b1, model[memWord]});
            if (if_gnt)  expQ.push_back('{1'b0, model[ifWord]});
            run = expMem ? ((run < 4) ? run + 1 : 4) : 0;
            @(posedge clk);
            #1;
            if (mem_gnt || expMem) begin
                memWord = (memWord + 1) % 16;
                mem_addr = BASE + 64'(memWord) * 8;
            end else begin
                ifWord = (ifWord + 1) % 16;
                if_addr = BASE + 64'(ifWord) * 8;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        idleCycles(3);

        $display("[TB] out-of-range accesses");
        applyStimulus(1, 0, 64'h7FFF_FFF8, 64'h0, 8'h0, w);
        applyStimulus(1, 0, 64'h8008_0000, 64'h0, 8'h0, w);
        applyStimulus(1, 1, 64'h7FFF_FFF8, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, w);
        applyStimulus(1, 0, 64'h8007_FFF8, 64'h0, 8'h0, w);
        idleCycles(2);

        $display("[TB] reset during read");
        if_req = 1'b1; if_addr = BASE + 64'h18;
        @(negedge clk);
        checkOutput("midGnt", if_gnt, 1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRvalid", if_rvalid, 0);
        checkOutput("midRdata", if_rdata, 0);
        checkOutput("midRamEn", ram_en, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        idleCycles(3);
        applyStimulus(0, 0, BASE + 64'h18, 64'h0, 8'h0, w);
        checkOutput("postRstGnt", 64'(w), 64'd0);
        idleCycles(2);

        $display("[TB] latency-2 instance");
        l2_if_req = 1'b1; l2_if_addr = BASE + 64'd40;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("l2Gnt", l2_if_gnt, (i % 2) == 0);
            checkOutput("l2Rvalid", l2_if_rvalid, (i >= 2) && ((i % 2) == 0));
            if ((i >= 2) && ((i % 2) == 0)) begin
                checkOutput("l2Rdata", l2_if_rdata, {48'hCAFE_0000_0000, 16'(5 + i / 2 - 1)});
            end
            @(posedge clk);
            #1;
            if ((i % 2) == 0) l2_if_addr = l2_if_addr + 64'd8;
        end
        l2_if_req = 1'b0;
        idleCycles(4);

        checkOutput("pendingResp", 64'(expQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
